// File: rtl/mem_fifo_read_adapter_if.sv
// Handshake bundle between the FIFO read adapter, memory_core's read port and
// the downstream ready/valid consumer.
interface mem_fifo_read_adapter_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  mem_ren;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output mem_ren,
        input  mem_data,
        input  mem_valid,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  mem_ren,
        output mem_data,
        output mem_valid,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/mem_fifo_read_adapter.sv
// Read-side stage for memory_core in FIFO mode: issues ren, absorbs the fixed
// 1-cycle return latency and re-times the data into a credit-managed skid buffer.
module mem_fifo_read_adapter #(
    parameter int DATA_WIDTH = 16,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    input  logic                   flush,
    mem_fifo_read_adapter_if.master bus,
    output logic [CNT_WIDTH-1:0]   rd_count,
    output logic [CNT_WIDTH-1:0]   empty_rd_count,
    output logic                   proto_err
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]        DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [CW-1:0]        CW_ONE  = CW'(1);
    localparam logic [PW-1:0]        PTR_ONE = PW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] skid_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] skid_d [BUF_DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  pending_q, pending_d;
    logic                  ign_q, ign_d;
    logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
    logic [CNT_WIDTH-1:0]  empty_cnt_q, empty_cnt_d;
    logic                  proto_err_q, proto_err_d;

    logic          active;
    logic          out_valid_int;
    logic          pop;
    logic [CW:0]   credit_sum;
    logic          mem_ren_int;
    logic          ret_live;
    logic          push_try;
    logic          full;
    logic          push;
    logic          drop;
    logic          stray;
    logic          empty_ret;

    always_comb begin
        active        = clk_en & ~reset & ~flush;
        out_valid_int = (count_q != '0);
        pop           = active & out_valid_int & bus.out_ready;
        // Credit covers stored words plus the one possibly in flight; a same-cycle
        // pop frees a slot so a 2-entry buffer can sustain one word per cycle.
        credit_sum    = {1'b0, count_q} + {{CW{1'b0}}, pending_q} - {{CW{1'b0}}, pop};
        mem_ren_int   = active & (credit_sum < {1'b0, DEPTH_C});
        // ign_q marks the cycle after a reset/flush that killed an in-flight read.
        ret_live      = active & ~ign_q;
        push_try      = ret_live & pending_q & bus.mem_valid;
        full          = (count_q == DEPTH_C);
        push          = push_try & (~full | pop);
        drop          = push_try & full & ~pop;
        stray         = ret_live & ~pending_q & bus.mem_valid;
        empty_ret     = ret_live & pending_q & ~bus.mem_valid;
    end

    always_comb begin
        skid_d      = skid_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        pending_d   = pending_q;
        ign_d       = ign_q;
        rd_count_d  = rd_count_q;
        empty_cnt_d = empty_cnt_q;
        proto_err_d = proto_err_q;

        if (reset) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            pending_d   = 1'b0;
            ign_d       = pending_q;
            rd_count_d  = '0;
            empty_cnt_d = '0;
            proto_err_d = 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                rd_ptr_d  = '0;
                wr_ptr_d  = '0;
                count_d   = '0;
                pending_d = 1'b0;
                ign_d     = pending_q;
            end else begin
                ign_d     = 1'b0;
                pending_d = mem_ren_int;
                if (push) begin
                    skid_d[wr_ptr_q] = bus.mem_data;
                    wr_ptr_d         = wr_ptr_q + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                    rd_count_d = rd_count_q + CNT_ONE;
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + CW_ONE;
                    2'b01:   count_d = count_q - CW_ONE;
                    default: count_d = count_q;
                endcase
                if (empty_ret) begin
                    empty_cnt_d = empty_cnt_q + CNT_ONE;
                end
                if (drop | stray) begin
                    proto_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        skid_q      <= skid_d;
        rd_ptr_q    <= rd_ptr_d;
        wr_ptr_q    <= wr_ptr_d;
        count_q     <= count_d;
        pending_q   <= pending_d;
        ign_q       <= ign_d;
        rd_count_q  <= rd_count_d;
        empty_cnt_q <= empty_cnt_d;
        proto_err_q <= proto_err_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (({1'b0, count_q} + {{CW{1'b0}}, pending_q}) <= {1'b0, DEPTH_C});
        end
    end

    assign bus.mem_ren   = mem_ren_int;
    assign bus.out_valid = out_valid_int & ~reset;
    assign bus.out_data  = skid_q[rd_ptr_q];
    assign rd_count       = reset ? '0 : rd_count_q;
    assign empty_rd_count = reset ? '0 : empty_cnt_q;
    assign proto_err      = proto_err_q & ~reset;

endmodule

// File: tb/tb_mem_fifo_read_adapter.sv
// Directed bench for mem_fifo_read_adapter; the bench emulates memory_core's
// 1-cycle read return and compares against hand-computed expectations.
module tb_mem_fifo_read_adapter;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        flush;
    logic [15:0] rd_count;
    logic [15:0] empty_rd_count;
    logic        proto_err;

    mem_fifo_read_adapter_if #(.DATA_WIDTH(16)) bus ();

    mem_fifo_read_adapter #(
        .DATA_WIDTH(16),
        .BUF_DEPTH (2),
        .CNT_WIDTH (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_en        (clk_en),
        .flush         (flush),
        .bus           (bus.master),
        .rd_count      (rd_count),
        .empty_rd_count(empty_rd_count),
        .proto_err     (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    logic [15:0] next_word;
    logic [15:0] step;
    logic        core_empty;
    logic [15:0] got [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock: log a transfer, cross the edge, then present the core's return.
    task automatic tick();
        logic ren_s;
        logic en_s;
        #1;
        ren_s = bus.mem_ren;
        en_s  = clk_en;
        if (en_s && !reset && !flush && bus.out_valid && bus.out_ready) begin
            got.push_back(bus.out_data);
        end
        @(posedge clk);
        #1;
        if (en_s) begin
            if (ren_s) begin
                bus.mem_valid = !core_empty;
                bus.mem_data  = core_empty ? 16'h0000 : next_word;
                if (!core_empty) next_word = next_word + step;
            end else begin
                bus.mem_valid = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        flush         = 1'b0;
        clk_en        = 1'b1;
        bus.out_ready = 1'b0;
        bus.mem_valid = 1'b0;
        core_empty    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        got.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        next_word     = 16'h0001;
        step          = 16'h0001;
        core_empty    = 1'b0;
        reset         = 1'b1;
        clk_en        = 1'b1;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_data  = 16'h0000;

        // Reset state
        repeat (3) tick();
        settle();
        check_val("rst_ren",   32'(bus.mem_ren),    32'd0);
        check_val("rst_valid", 32'(bus.out_valid),  32'd0);
        check_val("rst_rdcnt", 32'(rd_count),       32'd0);
        check_val("rst_empty", 32'(empty_rd_count), 32'd0);
        check_val("rst_perr",  32'(proto_err),      32'd0);

        // 1: streaming at one word per cycle
        do_reset();
        bus.out_ready = 1'b1;
        next_word     = 16'h0001;
        step          = 16'h0001;
        settle();
        check_val("t1_valid0", 32'(bus.out_valid), 32'd0);
        for (int c = 0; c < 10; c++) begin
            settle();
            check_val("t1_ren", 32'(bus.mem_ren), 32'd1);
            tick();
        end
        settle();
        check_val("t1_rdcnt", 32'(rd_count),   32'd8);
        check_val("t1_perr",  32'(proto_err),  32'd0);
        check_val("t1_head",  32'(bus.out_data), 32'h0009);
        check_val("t1_nwords", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            check_val("t1_word", 32'(got[i]), 32'(i + 1));
        end

        // 2: backpressure fills the buffer, then drains in order
        do_reset();
        next_word = 16'h000A;
        step      = 16'h0001;
        repeat (3) tick();
        settle();
        check_val("t2_valid", 32'(bus.out_valid), 32'd1);
        check_val("t2_head",  32'(bus.out_data),  32'h000A);
        check_val("t2_ren",   32'(bus.mem_ren),   32'd0);
        tick();
        settle();
        check_val("t2_ren_hold", 32'(bus.mem_ren),  32'd0);
        check_val("t2_head2",    32'(bus.out_data), 32'h000A);
        bus.out_ready = 1'b1;
        settle();
        check_val("t2_ren_pop", 32'(bus.mem_ren), 32'd1);
        repeat (6) tick();
        settle();
        check_val("t2_nwords", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            check_val("t2_word", 32'(got[i]), 32'(16'h000A + i));
        end
        check_val("t2_rdcnt", 32'(rd_count),       32'd6);
        check_val("t2_empty", 32'(empty_rd_count), 32'd0);

        // 3: core FIFO empty
        do_reset();
        core_empty    = 1'b1;
        bus.out_ready = 1'b1;
        repeat (6) tick();
        settle();
        check_val("t3_empty", 32'(empty_rd_count), 32'd5);
        check_val("t3_valid", 32'(bus.out_valid),  32'd0);
        check_val("t3_perr",  32'(proto_err),      32'd0);
        check_val("t3_rdcnt", 32'(rd_count),       32'd0);

        // 4: unsolicited mem_valid is sticky until reset
        do_reset();
        core_empty    = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_data  = 16'h0099;
        settle();
        check_val("t4_perr_pre", 32'(proto_err), 32'd0);
        tick();
        settle();
        check_val("t4_perr",  32'(proto_err),     32'd1);
        check_val("t4_valid", 32'(bus.out_valid), 32'd0);
        repeat (3) tick();
        settle();
        check_val("t4_perr_sticky", 32'(proto_err),     32'd1);
        check_val("t4_valid2",      32'(bus.out_valid), 32'd0);
        reset = 1'b1;
        settle();
        check_val("t4_rst_perr", 32'(proto_err),   32'd0);
        check_val("t4_rst_ren",  32'(bus.mem_ren), 32'd0);
        do_reset();
        settle();
        check_val("t4_post_perr", 32'(proto_err), 32'd0);

        // 5: flush with a full buffer, then flush with a read in flight
        do_reset();
        next_word = 16'h0055;
        step      = 16'h0011;
        repeat (3) tick();
        settle();
        check_val("t5_valid", 32'(bus.out_valid), 32'd1);
        check_val("t5_head",  32'(bus.out_data),  32'h0055);
        check_val("t5_ren",   32'(bus.mem_ren),   32'd0);
        bus.out_ready = 1'b1;
        flush         = 1'b1;
        settle();
        check_val("t5_flush_ren", 32'(bus.mem_ren), 32'd0);
        tick();
        flush = 1'b0;
        settle();
        check_val("t5_valid_after", 32'(bus.out_valid), 32'd0);
        check_val("t5_rdcnt",       32'(rd_count),      32'd0);
        check_val("t5_perr",        32'(proto_err),     32'd0);
        tick();
        flush = 1'b1;
        settle();
        check_val("t5_flush2_ren", 32'(bus.mem_ren), 32'd0);
        tick();
        flush         = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_data  = 16'h00EE;
        settle();
        check_val("t5_valid_f2", 32'(bus.out_valid), 32'd0);
        tick();
        settle();
        check_val("t5_perr_late", 32'(proto_err),     32'd0);
        check_val("t5_valid_end", 32'(bus.out_valid), 32'd0);
        check_val("t5_rdcnt_end", 32'(rd_count),      32'd0);

        // 6: clk_en low for three cycles mid-stream
        do_reset();
        next_word     = 16'h0071;
        step          = 16'h0001;
        bus.out_ready = 1'b1;
        repeat (7) tick();
        clk_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check_val("t6_ren_off", 32'(bus.mem_ren),   32'd0);
            check_val("t6_valid",   32'(bus.out_valid), 32'd1);
            check_val("t6_head",    32'(bus.out_data),  32'h0076);
            check_val("t6_rdcnt",   32'(rd_count),      32'd5);
            tick();
        end
        clk_en = 1'b1;
        settle();
        check_val("t6_ren_on", 32'(bus.mem_ren), 32'd1);
        repeat (3) tick();
        settle();
        check_val("t6_nwords", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            check_val("t6_word", 32'(got[i]), 32'(16'h0071 + i));
        end
        check_val("t6_rdcnt_end", 32'(rd_count),  32'd8);
        check_val("t6_perr",      32'(proto_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
